// File: rtl/decode_issue_stage_if.sv
// Fetch/writeback/execute-facing bundle of the decode/issue stage.
// The master drives instructions, writeback and out_ready; the slave is the stage.
interface decode_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            flush;
    logic [4:0]      writeback_writeaddr;
    logic [XLEN-1:0] writeback_writedata;
    logic            writeback_regwrite;
    logic            writeback_setflags;
    logic [3:0]      writeback_flags;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [7:0]      aluop;
    logic [4:0]      write_addr;
    logic            regwrite;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
    logic            setflags;
    logic [3:0]      flags;

    modport master (
        output in_valid, instruction, flush,
        output writeback_writeaddr, writeback_writedata,
        output writeback_regwrite, writeback_setflags,
        output writeback_flags, out_ready,
        input  in_ready, out_valid, operand_a, operand_b,
        input  aluop, write_addr, regwrite, memwrite,
        input  memtoreg, branch, setflags, flags
    );

    modport slave (
        input  in_valid, instruction, flush,
        input  writeback_writeaddr, writeback_writedata,
        input  writeback_regwrite, writeback_setflags,
        input  writeback_flags, out_ready,
        output in_ready, out_valid, operand_a, operand_b,
        output aluop, write_addr, regwrite, memwrite,
        output memtoreg, branch, setflags, flags
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue: register read, RAW scoreboard, one-entry output register.
// Define DECODE_BYPASS_EN to forward same-cycle writeback into issue.
module decode_issue_stage #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int IMM_W    = 8
) (
    input logic                 clk,
    input logic                 rst,
    decode_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [7:0]      aluop;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            memtoreg;
        logic            branch;
        logic            setflags;
        logic [3:0]      flags;
    } bundle_t;

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [31:0]     pending;
    logic [3:0]      flags_q;
    logic            flags_pending;
    logic            out_v;
    bundle_t         out_q;
    bundle_t         next_b;

    function automatic logic arch_reg(input logic [4:0] r);
        return (r != 5'd0) && (32'(r) < NUM_REGS);
    endfunction

    logic [31:0]      insn;
    logic [4:0]       ra, rb, rd;
    logic             use_imm, br;
    logic [IMM_W-1:0] imm;
    logic [XLEN-1:0]  imm_ext;

    assign insn    = bus.instruction;
    assign use_imm = insn[8];
    assign br      = insn[12];
    assign rd      = insn[18:14];
    assign ra      = insn[23:19];
    assign rb      = insn[28:24];
    assign imm     = insn[31:32-IMM_W];
    assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

    logic [XLEN-1:0] rf_a, rf_b, src_a, src_b;
    logic [3:0]      issue_flags;
    logic            wb_we, ra_sb, rb_sb, flags_sb;

    assign rf_a  = arch_reg(ra) ? regs[ra] : '0;
    assign rf_b  = arch_reg(rb) ? regs[rb] : '0;
    assign wb_we = bus.writeback_regwrite
                && arch_reg(bus.writeback_writeaddr);

`ifdef DECODE_BYPASS_EN
    logic wb_hit_a, wb_hit_b;
    assign wb_hit_a    = wb_we && (bus.writeback_writeaddr == ra);
    assign wb_hit_b    = wb_we && (bus.writeback_writeaddr == rb);
    assign ra_sb       = pending[ra] && !wb_hit_a;
    assign rb_sb       = pending[rb] && !wb_hit_b;
    assign flags_sb    = flags_pending && !bus.writeback_setflags;
    assign src_a       = wb_hit_a ? bus.writeback_writedata : rf_a;
    assign src_b       = wb_hit_b ? bus.writeback_writedata : rf_b;
    assign issue_flags = bus.writeback_setflags ? bus.writeback_flags
                                                : flags_q;
`else
    assign ra_sb       = pending[ra];
    assign rb_sb       = pending[rb];
    assign flags_sb    = flags_pending;
    assign src_a       = rf_a;
    assign src_b       = rf_b;
    assign issue_flags = flags_q;
`endif

    // The held bundle has not reached the scoreboard yet, so match it too.
    logic ra_fly, rb_fly, hazard, load, fire;
    assign ra_fly = out_v && out_q.regwrite && (out_q.rd == ra);
    assign rb_fly = out_v && out_q.regwrite && (out_q.rd == rb);
    assign hazard = (arch_reg(ra) && (ra_sb || ra_fly))
                 || (!use_imm && arch_reg(rb) && (rb_sb || rb_fly))
                 || (br && (flags_sb || (out_v && out_q.setflags)));

    assign bus.in_ready = (!out_v || bus.out_ready) && !hazard
                       && !bus.flush;
    assign load = bus.in_valid && bus.in_ready;
    assign fire = out_v && bus.out_ready && !bus.flush;

    always_comb begin
        next_b          = '0;
        next_b.a        = src_a;
        next_b.b        = use_imm ? imm_ext : src_b;
        next_b.aluop    = insn[7:0];
        next_b.regwrite = insn[9];
        next_b.memwrite = insn[10];
        next_b.memtoreg = insn[11];
        next_b.branch   = br;
        next_b.setflags = insn[13];
        next_b.rd       = rd;
        next_b.flags    = issue_flags;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v <= 1'b0;
            out_q <= '0;
        end else if (bus.flush) begin
            out_v <= 1'b0;
        end else if (load) begin
            out_v <= 1'b1;
            out_q <= next_b;
        end else if (bus.out_ready) begin
            out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flags_q <= '0;
        end else begin
            if (wb_we)
                regs[bus.writeback_writeaddr] <= bus.writeback_writedata;
            if (bus.writeback_setflags)
                flags_q <= bus.writeback_flags;
        end
    end

    // Set is written after clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending       <= '0;
            flags_pending <= 1'b0;
        end else begin
            if (wb_we)
                pending[bus.writeback_writeaddr] <= 1'b0;
            if (fire && out_q.regwrite && arch_reg(out_q.rd))
                pending[out_q.rd] <= 1'b1;
            if (bus.writeback_setflags)
                flags_pending <= 1'b0;
            if (fire && out_q.setflags)
                flags_pending <= 1'b1;
        end
    end

    assign bus.out_valid  = out_v;
    assign bus.operand_a  = out_q.a;
    assign bus.operand_b  = out_q.b;
    assign bus.aluop      = out_q.aluop;
    assign bus.write_addr = out_q.rd;
    assign bus.regwrite   = out_q.regwrite;
    assign bus.memwrite   = out_q.memwrite;
    assign bus.memtoreg   = out_q.memtoreg;
    assign bus.branch     = out_q.branch;
    assign bus.setflags   = out_q.setflags;
    assign bus.flags      = out_q.flags;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with a per-cycle reference model.
// Works with or without DECODE_BYPASS_EN defined.
module tb_decode_issue_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_stage_if #(.XLEN(64)) bus ();

    decode_issue_stage #(
        .XLEN(64), .NUM_REGS(32), .IMM_W(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: architectural state plus the one held bundle.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  ctl;
        logic [3:0]  fl;
    } mb_t;

    logic [63:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_fpend;
    logic [3:0]  m_flags;
    logic        m_ov;
    mb_t         m_b;

    function automatic logic [63:0] m_src(input logic [4:0] r);
        if (r == 5'd0) return 64'd0;
`ifdef DECODE_BYPASS_EN
        if (bus.writeback_regwrite && bus.writeback_writeaddr == r)
            return bus.writeback_writedata;
`endif
        return m_regs[r];
    endfunction

    function automatic bit m_src_hz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_ov && m_b.ctl[4] && m_b.rd == r) return 1'b1;
        if (!m_pend[r]) return 1'b0;
`ifdef DECODE_BYPASS_EN
        if (bus.writeback_regwrite && bus.writeback_writeaddr == r)
            return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        logic [31:0] i;
        bit hz;
        bit fwait;
        i = bus.instruction;
        fwait = m_fpend;
`ifdef DECODE_BYPASS_EN
        if (bus.writeback_setflags) fwait = 1'b0;
`endif
        hz = m_src_hz(i[23:19]) || (!i[8] && m_src_hz(i[28:24]));
        if (i[12] && (fwait || (m_ov && m_b.ctl[0]))) hz = 1'b1;
        return (!m_ov || bus.out_ready) && !hz && !bus.flush;
    endfunction

    function automatic mb_t m_decode();
        mb_t r;
        logic [31:0] i;
        i     = bus.instruction;
        r.a   = m_src(i[23:19]);
        r.b   = i[8] ? 64'($signed(i[31:24])) : m_src(i[28:24]);
        r.op  = i[7:0];
        r.rd  = i[18:14];
        r.ctl = {i[9], i[10], i[11], i[12], i[13]};
        r.fl  = m_flags;
`ifdef DECODE_BYPASS_EN
        if (bus.writeback_setflags) r.fl = bus.writeback_flags;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] <= 64'd0;
            m_pend  <= '0;
            m_fpend <= 1'b0;
            m_flags <= '0;
            m_ov    <= 1'b0;
            m_b     <= '0;
        end else begin
            if (bus.writeback_regwrite && bus.writeback_writeaddr != 0) begin
                m_regs[bus.writeback_writeaddr] <= bus.writeback_writedata;
                m_pend[bus.writeback_writeaddr] <= 1'b0;
            end
            if (bus.writeback_setflags) begin
                m_flags <= bus.writeback_flags;
                m_fpend <= 1'b0;
            end
            if (m_ov && bus.out_ready && !bus.flush) begin
                if (m_b.ctl[4] && m_b.rd != 0) m_pend[m_b.rd] <= 1'b1;
                if (m_b.ctl[0]) m_fpend <= 1'b1;
            end
            if (bus.flush) m_ov <= 1'b0;
            else if (bus.in_valid && m_ready()) begin
                m_ov <= 1'b1;
                m_b  <= m_decode();
            end else if (bus.out_ready) m_ov <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end else begin
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, m_ready()});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
            if (m_ov) begin
                chk("operand_a", bus.operand_a, m_b.a);
                chk("operand_b", bus.operand_b, m_b.b);
                chk("aluop", {56'd0, bus.aluop}, {56'd0, m_b.op});
                chk("write_addr", {59'd0, bus.write_addr}, {59'd0, m_b.rd});
                chk("ctl", {59'd0, bus.regwrite, bus.memwrite, bus.memtoreg,
                            bus.branch, bus.setflags}, {59'd0, m_b.ctl});
                chk("flags", {60'd0, bus.flags}, {60'd0, m_b.fl});
            end
        end
    end

    function automatic logic [31:0] mk(
        input logic [7:0] op, input logic ui, input logic rw,
        input logic mw, input logic mtr, input logic br,
        input logic sf, input logic [4:0] rd, input logic [4:0] ra,
        input logic [4:0] rb, input logic [7:0] imm);
        logic [31:0] w;
        w = '0;
        w[7:0]   = op;
        w[8]     = ui;
        w[9]     = rw;
        w[10]    = mw;
        w[11]    = mtr;
        w[12]    = br;
        w[13]    = sf;
        w[18:14] = rd;
        w[23:19] = ra;
        if (ui) w[31:24] = imm;
        else w[28:24] = rb;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        chk(nm, act, exp);
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 0;
        bus.instruction = '0;
        bus.flush = 0;
        bus.writeback_writeaddr = '0;
        bus.writeback_writedata = '0;
        bus.writeback_regwrite = 0;
        bus.writeback_setflags = 0;
        bus.writeback_flags = '0;
        bus.out_ready = 1;
        step();
        step();
        lit("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        lit("reset_flags", {60'd0, bus.flags}, 64'd0);
        rst = 1'b1;

        // Writeback r5 then read it.
        bus.writeback_regwrite = 1;
        bus.writeback_writeaddr = 5;
        bus.writeback_writedata = 64'h1234;
        step();
        bus.writeback_regwrite = 0;
        bus.instruction = mk(8'd1, 0, 1, 0, 0, 0, 0, 6, 5, 0, 0);
        bus.in_valid = 1;
        #1;
        lit("t1_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        lit("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
        lit("t1_operand_a", bus.operand_a, 64'h1234);
        lit("t1_operand_b", bus.operand_b, 64'h0);
        lit("t1_write_addr", {59'd0, bus.write_addr}, 64'd6);

        // RAW on r7 resolved by writeback.
        bus.instruction = mk(8'd2, 0, 1, 1, 0, 0, 0, 7, 0, 0, 0);
        bus.in_valid = 1;
        step();
        bus.instruction = mk(8'd3, 0, 1, 0, 1, 0, 0, 11, 7, 0, 0);
        #1;
        lit("t2_stall_fly", {63'd0, bus.in_ready}, 64'd0);
        step();
        lit("t2_stall_pend0", {63'd0, bus.in_ready}, 64'd0);
        step();
        lit("t2_stall_pend1", {63'd0, bus.in_ready}, 64'd0);
        bus.writeback_regwrite = 1;
        bus.writeback_writeaddr = 7;
        bus.writeback_writedata = 64'hAA;
        #1;
`ifdef DECODE_BYPASS_EN
        lit("t2_wb_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        bus.writeback_regwrite = 0;
`else
        lit("t2_wb_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.writeback_regwrite = 0;
        #1;
        lit("t2_after_wb_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
`endif
        lit("t2_out_valid", {63'd0, bus.out_valid}, 64'd1);
        lit("t2_operand_a", bus.operand_a, 64'hAA);

        // Backpressure for three cycles.
        bus.instruction = mk(8'd3, 0, 1, 0, 0, 0, 0, 8, 5, 0, 0);
        bus.in_valid = 1;
        step();
        bus.out_ready = 0;
        bus.instruction = mk(8'd4, 0, 1, 0, 0, 0, 0, 9, 0, 0, 0);
        #1;
        for (int c = 0; c < 3; c++) begin
            lit("t3_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            lit("t3_hold_a", bus.operand_a, 64'h1234);
            lit("t3_hold_op", {56'd0, bus.aluop}, 64'd3);
            lit("t3_hold_ready", {63'd0, bus.in_ready}, 64'd0);
            step();
        end
        bus.out_ready = 1;
        #1;
        lit("t3_release_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        lit("t3_next_op", {56'd0, bus.aluop}, 64'd4);
        lit("t3_next_rd", {59'd0, bus.write_addr}, 64'd9);

        // Immediate: rb field (22) pending must not stall.
        bus.instruction = mk(8'd5, 0, 1, 0, 0, 0, 0, 22, 0, 0, 0);
        bus.in_valid = 1;
        step();
        bus.instruction = mk(8'd6, 1, 0, 0, 0, 0, 0, 12, 0, 0, 8'hF6);
        #1;
        lit("t4_imm_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        lit("t4_operand_b", bus.operand_b, 64'hFFFF_FFFF_FFFF_FFF6);
        lit("t4_operand_a", bus.operand_a, 64'h0);

        // Branch waits for flags.
        bus.instruction = mk(8'd7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        bus.in_valid = 1;
        step();
        bus.instruction = mk(8'd8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        #1;
        lit("t5_stall_fly", {63'd0, bus.in_ready}, 64'd0);
        step();
        lit("t5_stall_pend0", {63'd0, bus.in_ready}, 64'd0);
        step();
        lit("t5_stall_pend1", {63'd0, bus.in_ready}, 64'd0);
        bus.writeback_setflags = 1;
        bus.writeback_flags = 4'b0100;
        #1;
`ifdef DECODE_BYPASS_EN
        lit("t5_wb_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.writeback_setflags = 0;
        bus.in_valid = 0;
`else
        lit("t5_wb_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        bus.writeback_setflags = 0;
        #1;
        lit("t5_after_wb_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
`endif
        lit("t5_out_valid", {63'd0, bus.out_valid}, 64'd1);
        lit("t5_flags", {60'd0, bus.flags}, 64'h4);
        lit("t5_branch", {63'd0, bus.branch}, 64'd1);

        // Flush drops rd=3 before it reaches the scoreboard.
        bus.instruction = mk(8'd9, 0, 1, 0, 0, 0, 0, 3, 5, 0, 0);
        bus.in_valid = 1;
        step();
        bus.in_valid = 0;
        bus.flush = 1;
        step();
        bus.flush = 0;
        lit("t6_flushed", {63'd0, bus.out_valid}, 64'd0);
        bus.instruction = mk(8'd10, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        bus.in_valid = 1;
        #1;
        lit("t6_reader_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        lit("t6_reader_valid", {63'd0, bus.out_valid}, 64'd1);

        // Reset while stalled.
        bus.instruction = mk(8'd11, 0, 1, 0, 0, 0, 0, 10, 5, 0, 0);
        bus.in_valid = 1;
        step();
        bus.out_ready = 0;
        bus.instruction = mk(8'd12, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0);
        #1;
        lit("t7_stall", {63'd0, bus.in_ready}, 64'd0);
        step();
        lit("t7_stall_hold", {63'd0, bus.in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        lit("t7_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        lit("t7_rst_a", bus.operand_a, 64'd0);
        lit("t7_rst_rd", {59'd0, bus.write_addr}, 64'd0);
        lit("t7_rst_rw", {63'd0, bus.regwrite}, 64'd0);
        lit("t7_rst_flags", {60'd0, bus.flags}, 64'd0);
        lit("t7_rst_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        rst = 1'b1;
        bus.out_ready = 1;
        bus.instruction = mk(8'd13, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        #1;
        lit("t7_post_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 0;
        lit("t7_post_valid", {63'd0, bus.out_valid}, 64'd1);
        lit("t7_regs_cleared", bus.operand_a, 64'd0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
